// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial front end of the sequence detector.
package serializer_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out shifter with a single-entry holding register so that
// consecutive words stream onto X without an idle gap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | shifter empty, X parked at IDLE_BIT
// S_SHIFT | shifter holds a word, cnt counts remaining bits WIDTH..1
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             X,
   output logic             X_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] hold, hold_n;
   logic             hold_full, hold_full_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             x_n;
   logic             accept;
   logic             last_bit;

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign load_ready = !hold_full;
   assign accept     = load_valid && load_ready;
   assign last_bit   = (state == S_SHIFT) && (cnt == CW'(1));
   assign X_valid    = (state == S_SHIFT);
   assign word_done  = last_bit;
   assign busy       = (state == S_SHIFT) || hold_full;

   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      hold_n      = hold;
      hold_full_n = hold_full;
      cnt_n       = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n = S_SHIFT;
               shreg_n = data_in;
               cnt_n   = CW'(WIDTH);
            end
         end
         S_SHIFT: begin
            if (cnt == CW'(1)) begin
               // ready is low whenever hold_full, so these branches never collide
               if (hold_full) begin
                  shreg_n     = hold;
                  cnt_n       = CW'(WIDTH);
                  hold_full_n = 1'b0;
               end else if (accept) begin
                  shreg_n = data_in;
                  cnt_n   = CW'(WIDTH);
               end else begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end else begin
               shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
               cnt_n   = cnt - CW'(1);
               if (accept) begin
                  hold_n      = data_in;
                  hold_full_n = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
      // X is precomputed from next state so the output pin comes straight off a flop
      x_n = (state_n == S_SHIFT) ? head_bit(shreg_n) : IDLE_BIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
         X         <= IDLE_BIT;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         cnt       <= cnt_n;
         X         <= x_n;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two WIDTH=4 builds (MSB-first/idle 0 and
// LSB-first/idle 1) driven in lockstep and checked against a bit-queue model.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] data_in = '0;
   logic       load_valid = 1'b0;

   logic xa, xva, done_a, rdy_a, busy_a;
   logic xb, xvb, done_b, rdy_b, busy_b;

   bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
      .load_ready(rdy_a), .X(xa), .X_valid(xva), .word_done(done_a), .busy(busy_a)
   );

   bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
      .load_ready(rdy_b), .X(xb), .X_valid(xvb), .word_done(done_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   // Model: every accepted word becomes four queued bit slots; one slot leaves per cycle.
   typedef struct {
      logic [3:0] w;
      int         idx;
   } slot_t;
   slot_t q[$];

   int total = 0;
   int bad   = 0;
   int xv_count = 0;
   int done_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return q.size() <= 4;
   endfunction

   task automatic check_model();
      logic ev, exa, exb, edone;
      ev    = q.size() > 0;
      exa   = ev ? q[0].w[3 - q[0].idx] : 1'b0;
      exb   = ev ? q[0].w[q[0].idx]     : 1'b1;
      edone = ev && (q[0].idx == 3);
      chk("a_X",       {31'd0, xa},     {31'd0, exa});
      chk("a_X_valid", {31'd0, xva},    {31'd0, ev});
      chk("a_done",    {31'd0, done_a}, {31'd0, edone});
      chk("a_ready",   {31'd0, rdy_a},  {31'd0, m_ready()});
      chk("a_busy",    {31'd0, busy_a}, {31'd0, ev});
      chk("b_X",       {31'd0, xb},     {31'd0, exb});
      chk("b_X_valid", {31'd0, xvb},    {31'd0, ev});
      chk("b_done",    {31'd0, done_b}, {31'd0, edone});
      chk("b_ready",   {31'd0, rdy_b},  {31'd0, m_ready()});
   endtask

   task automatic cycle(input logic v, input logic [3:0] d);
      bit acc;
      load_valid = v;
      data_in    = d;
      acc = v && m_ready();
      @(posedge clk);
      #1;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) for (int i = 0; i < 4; i++) q.push_back('{w: d, idx: i});
      if (xva) xv_count++;
      if (done_a) done_count++;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      rst = 1'b0;
      chk("rst_a_X",     {31'd0, xa},     32'd0);
      chk("rst_a_Xv",    {31'd0, xva},    32'd0);
      chk("rst_a_done",  {31'd0, done_a}, 32'd0);
      chk("rst_a_ready", {31'd0, rdy_a},  32'd1);
      chk("rst_a_busy",  {31'd0, busy_a}, 32'd0);
      chk("rst_b_X",     {31'd0, xb},     32'd1);
      chk("rst_b_busy",  {31'd0, busy_b}, 32'd0);
   endtask

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       xa;
      logic       xb;
      logic       xv;
      logic       done;
      logic       rdy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [3:0] d, input logic ea, input logic eb,
                      input logic ev, input logic ed, input logic er);
      tbl.push_back('{v: v, d: d, xa: ea, xb: eb, xv: ev, done: ed, rdy: er});
   endtask

   initial begin
      int cyc;
      int words;

      // single word 1011
      add(1, 4'b1011, 1, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 0, 0, 1);
      // back-to-back 1011, 0110 with valid held while the second word waits
      add(1, 4'b1011, 1, 1, 1, 0, 1);
      add(1, 4'b0110, 0, 1, 1, 0, 0);
      add(1, 4'b0110, 1, 0, 1, 0, 0);
      add(1, 4'b0110, 1, 1, 1, 1, 0);
      add(0, 4'b0000, 0, 0, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 0, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 0, 0, 1);
      // load exactly on the last-bit cycle, hold register stays unused
      add(1, 4'b1011, 1, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1, 1);
      add(1, 4'b0001, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 0, 1, 0, 1);
      add(0, 4'b0000, 0, 0, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 0, 0, 1);

      do_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].v, tbl[i].d);
         chk($sformatf("vec%0d_a_X", i),   {31'd0, xa},     {31'd0, tbl[i].xa});
         chk($sformatf("vec%0d_b_X", i),   {31'd0, xb},     {31'd0, tbl[i].xb});
         chk($sformatf("vec%0d_Xv", i),    {31'd0, xva},    {31'd0, tbl[i].xv});
         chk($sformatf("vec%0d_done", i),  {31'd0, done_a}, {31'd0, tbl[i].done});
         chk($sformatf("vec%0d_ready", i), {31'd0, rdy_a},  {31'd0, tbl[i].rdy});
      end

      // reset on cycle 2 of a word with a second word held
      cycle(1, 4'b1011);
      cycle(1, 4'b0110);
      chk("pre_rst_ready", {31'd0, rdy_a}, 32'd0);
      do_reset();
      cycle(1, 4'b0001);
      chk("post_rst_b0", {31'd0, xa}, 32'd0);
      cycle(0, 4'b0000);
      chk("post_rst_b1", {31'd0, xa}, 32'd0);
      cycle(0, 4'b0000);
      chk("post_rst_b2", {31'd0, xa}, 32'd0);
      cycle(0, 4'b0000);
      chk("post_rst_b3", {31'd0, xa}, 32'd1);
      chk("post_rst_done", {31'd0, done_a}, 32'd1);
      cycle(0, 4'b0000);
      chk("post_rst_idle", {31'd0, xva}, 32'd0);

      // random stream of 200 words with random gaps
      xv_count = 0;
      done_count = 0;
      words = 0;
      cyc = 0;
      while (words < 200 && cyc < 5000) begin
         logic       v;
         logic [3:0] d;
         v = ($urandom_range(0, 9) < 6);
         d = 4'($urandom);
         if (v && m_ready()) words++;
         cycle(v, d);
         cyc++;
      end
      chk("rand_words_accepted", words, 200);
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
         cycle(0, 4'b0000);
         cyc++;
      end
      cycle(0, 4'b0000);
      chk("rand_xv_cycles", xv_count, 800);
      chk("rand_word_done", done_count, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
